// File: rtl/logic_unit_arbiter.sv
// Round-robin sequencer sharing one combinational 16-bit logic unit.
// One request in flight: IDLE accepts, ISSUE captures, RESP returns.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_x,
    input  logic [WIDTH*N_REQ-1:0] req_y,
    output logic [WIDTH-1:0]       lu_x,
    output logic [WIDTH-1:0]       lu_y,
    output logic [1:0]             lu_op,
    input  logic [WIDTH-1:0]       lu_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  gnt;
    logic [ID_W:0]    cand;
    logic             gnt_ok;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [1:0]       sel_op;

    // Search ptr, ptr+1, ... wrapping; the first valid requester wins.
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!gnt_ok && req_valid[cand[ID_W-1:0]]) begin
                gnt    = cand[ID_W-1:0];
                gnt_ok = 1'b1;
            end
        end
    end

    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        sel_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt == ID_W'(i)) begin
                sel_x  = req_x[i*WIDTH +: WIDTH];
                sel_y  = req_y[i*WIDTH +: WIDTH];
                sel_op = req_op[2*i +: 2];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_ok)
            req_ready[gnt] = 1'b1;
    end

    assign ptr_nxt = (rsp_id == ID_W'(N_REQ-1)) ? '0 : rsp_id + 1'b1;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_ok) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            lu_x      <= '0;
            lu_y      <= '0;
            lu_op     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        lu_x   <= sel_x;
                        lu_y   <= sel_y;
                        lu_op  <= sel_op;
                        rsp_id <= gnt;
                    end
                end
                ISSUE: begin
                    rsp_data  <= lu_out;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
